// File: rtl/instr_fetch.sv
// -----------------------------------------------------------------------------
// instr_fetch
//   Instruction fetch/sequencer feeding the CPU core one word per cycle.
//   A loadable instruction memory is stepped through by a program counter
//   once start is seen. The program ends on a HALT word (never issued) or
//   after the word at the latched last address has been issued. NOP words
//   are driven on stall and whenever no program word is being issued.
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous active-low reset (memory contents survive it)
//   load_en      write load_data to mem[load_addr]; honoured in IDLE/HALT only
//   load_addr    memory write address
//   load_data    memory write data
//   last_addr    address of the final program word, captured on start
//   start        begin execution from address 0 (ignored while load_en=1)
//   stall        hold the PC and issue a NOP this cycle
//   instruction  registered word to the core
//   instr_valid  instruction is a real program word
//   pc           address of the next word to fetch
//   busy         sequencer is running
//   done         sequencer has halted
// -----------------------------------------------------------------------------
module instr_fetch #(
    parameter int                     INSTR_WIDTH = 20,
    parameter int                     PC_BITS     = 5,
    parameter logic [INSTR_WIDTH-1:0] NOP_INSTR   = '0,
    parameter logic [INSTR_WIDTH-1:0] HALT_INSTR  = '1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   load_en,
    input  logic [PC_BITS-1:0]     load_addr,
    input  logic [INSTR_WIDTH-1:0] load_data,
    input  logic [PC_BITS-1:0]     last_addr,
    input  logic                   start,
    input  logic                   stall,
    output logic [INSTR_WIDTH-1:0] instruction,
    output logic                   instr_valid,
    output logic [PC_BITS-1:0]     pc,
    output logic                   busy,
    output logic                   done
);

    localparam int DEPTH = 1 << PC_BITS;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    // Word presented to the core together with its qualifier.
    typedef struct packed {
        logic [INSTR_WIDTH-1:0] word;
        logic                   valid;
    } issue_t;

    state_t                 state_q, state_d;
    logic [PC_BITS-1:0]     pc_q, pc_d;
    logic [PC_BITS-1:0]     last_q, last_d;
    issue_t                 out_q, out_d;

    logic [INSTR_WIDTH-1:0] mem [DEPTH];
    logic [INSTR_WIDTH-1:0] fetch_word;
    logic                   load_ok;

    // ------------------------------------------------------------------
    // Instruction memory. Deliberately outside the reset domain so a
    // reset does not wipe a loaded program; writes are locked out while
    // a program is executing.
    // ------------------------------------------------------------------
    assign load_ok = load_en && (state_q != RUN);

    always_ff @(posedge clk) begin
        if (load_ok) begin
            mem[load_addr] <= load_data;
        end
    end

    assign fetch_word = mem[pc_q];

    // ------------------------------------------------------------------
    // Next-state / issue logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        last_d      = last_q;
        out_d.word  = NOP_INSTR;
        out_d.valid = 1'b0;

        case (state_q)
            IDLE, HALT: begin
                // A simultaneous load wins; start is simply dropped.
                if (start && !load_en) begin
                    state_d = RUN;
                    pc_d    = '0;
                    last_d  = last_addr;
                end
            end

            RUN: begin
                // Stall outranks both halt conditions: nothing is
                // fetched, so neither can be observed this cycle.
                if (!stall) begin
                    if (fetch_word == HALT_INSTR) begin
                        state_d = HALT;
                    end else begin
                        out_d.word  = fetch_word;
                        out_d.valid = 1'b1;
                        // The last word is still issued; pc stays on it
                        // so a top-of-memory last address never wraps.
                        if (pc_q == last_q) begin
                            state_d = HALT;
                        end else begin
                            pc_d = pc_q + PC_BITS'(1);
                        end
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            pc_q        <= '0;
            last_q      <= '0;
            out_q.word  <= NOP_INSTR;
            out_q.valid <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            last_q  <= last_d;
            out_q   <= out_d;
        end
    end

    assign instruction = out_q.word;
    assign instr_valid = out_q.valid;
    assign pc          = pc_q;
    assign busy        = (state_q == RUN);
    assign done        = (state_q == HALT);

endmodule

// File: tb/tb_instr_fetch.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch
//   Directed bench for instr_fetch. Stimulus pushes the words each program
//   is expected to issue into a scoreboard queue; an independent monitor
//   pops and compares on every valid word and checks NOP otherwise.
// -----------------------------------------------------------------------------
module tb_instr_fetch;

    localparam int IW = 20;
    localparam int PB = 5;
    localparam logic [IW-1:0] NOP = 20'h00000;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          load_en = 1'b0;
    logic [PB-1:0] load_addr = '0;
    logic [IW-1:0] load_data = '0;
    logic [PB-1:0] last_addr = '0;
    logic          start = 1'b0;
    logic          stall = 1'b0;
    logic [IW-1:0] instruction;
    logic          instr_valid;
    logic [PB-1:0] pc;
    logic          busy;
    logic          done;

    int tests = 0;
    int fails = 0;
    int issued = 0;
    logic [IW-1:0] sb[$];

    instr_fetch #(
        .INSTR_WIDTH(IW),
        .PC_BITS    (PB),
        .NOP_INSTR  (20'h00000),
        .HALT_INSTR (20'hFFFFF)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .load_en    (load_en),
        .load_addr  (load_addr),
        .load_data  (load_data),
        .last_addr  (last_addr),
        .start      (start),
        .stall      (stall),
        .instruction(instruction),
        .instr_valid(instr_valid),
        .pc         (pc),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: decoupled from stimulus, samples on the falling edge.
    always @(negedge clk) begin
        if (rst) begin
            if (instr_valid) begin
                issued++;
                if (sb.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL sb_unexpected: got %0h expected no word at %0t", instruction, $time);
                end else begin
                    chk("sb_word", instruction, sb.pop_front());
                end
            end else begin
                chk("nop_when_invalid", instruction, NOP);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [PB-1:0] a, input logic [IW-1:0] d);
        load_en   = 1'b1;
        load_addr = a;
        load_data = d;
        tick();
        load_en   = 1'b0;
    endtask

    task automatic go(input logic [PB-1:0] last);
        last_addr = last;
        start     = 1'b1;
        tick();
        start     = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int n = 0;
        while (!done && n < budget) begin
            tick();
            n++;
        end
        chk(name, done, 1);
    endtask

    initial begin
        // ---------------- reset state ----------------
        #2 rst = 1'b0;
        #2;
        chk("rst_instr", instruction, NOP);
        chk("rst_valid", instr_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_pc", pc, 0);
        @(negedge clk);
        rst = 1'b1;
        tick();

        // ---------------- basic 4-word program ----------------
        load(5'd0, 20'h10203);
        load(5'd1, 20'h20104);
        load(5'd2, 20'h31005);
        load(5'd3, 20'h40000);
        sb.push_back(20'h10203);
        sb.push_back(20'h20104);
        sb.push_back(20'h31005);
        sb.push_back(20'h40000);
        go(5'd3);
        chk("t1_busy", busy, 1);
        chk("t1_pc0", pc, 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t1_consec_valid", instr_valid, 1);
        end
        chk("t1_done_on_last", done, 1);
        tick();
        chk("t1_done", done, 1);
        chk("t1_instr_nop", instruction, NOP);
        chk("t1_valid0", instr_valid, 0);
        chk("t1_pc", pc, 3);
        chk("t1_sb_empty", sb.size(), 0);

        // ---------------- HALT word stops program ----------------
        load(5'd2, 20'hFFFFF);
        sb.push_back(20'h10203);
        sb.push_back(20'h20104);
        go(5'd7);
        wait_done("t2_done", 10);
        tick();
        chk("t2_pc", pc, 2);
        chk("t2_valid0", instr_valid, 0);
        chk("t2_sb_empty", sb.size(), 0);

        // ---------------- stall for two cycles ----------------
        load(5'd2, 20'h31005);
        sb.push_back(20'h10203);
        sb.push_back(20'h20104);
        sb.push_back(20'h31005);
        sb.push_back(20'h40000);
        go(5'd3);
        tick();
        chk("t3_first_pc", pc, 1);
        stall = 1'b1;
        tick();
        chk("t3_stall1_valid", instr_valid, 0);
        chk("t3_stall1_pc", pc, 1);
        tick();
        chk("t3_stall2_valid", instr_valid, 0);
        chk("t3_stall2_pc", pc, 1);
        stall = 1'b0;
        wait_done("t3_done", 10);
        tick();
        chk("t3_pc", pc, 3);
        chk("t3_sb_empty", sb.size(), 0);

        // ---------------- full memory, last_addr = 31 ----------------
        for (int i = 0; i < 32; i++) begin
            load(5'(i), 20'h50000 | 20'(i));
            sb.push_back(20'h50000 | 20'(i));
        end
        issued = 0;
        go(5'd31);
        wait_done("t4_done", 40);
        tick();
        tick();
        chk("t4_issued", issued, 32);
        chk("t4_pc_nowrap", pc, 31);
        chk("t4_sb_empty", sb.size(), 0);

        // ---------------- start + load_en together in IDLE ----------------
        rst = 1'b0;
        #2;
        chk("t5_rst_done", done, 0);
        @(negedge clk);
        rst = 1'b1;
        tick();
        load_en   = 1'b1;
        load_addr = 5'd5;
        load_data = 20'h12345;
        last_addr = 5'd5;
        start     = 1'b1;
        tick();
        load_en   = 1'b0;
        start     = 1'b0;
        chk("t5_busy", busy, 0);
        chk("t5_done", done, 0);
        tick();
        chk("t5_busy_later", busy, 0);
        for (int i = 0; i < 5; i++) sb.push_back(20'h50000 | 20'(i));
        sb.push_back(20'h12345);
        go(5'd5);
        wait_done("t5_run_done", 12);
        tick();
        chk("t5_pc", pc, 5);
        chk("t5_sb_empty", sb.size(), 0);

        // ---------------- asynchronous reset mid-run ----------------
        for (int i = 0; i < 5; i++) sb.push_back(20'h50000 | 20'(i));
        go(5'd31);
        tick();
        tick();
        chk("t6_running", busy, 1);
        #2 rst = 1'b0;
        #1;
        chk("t6_async_instr", instruction, NOP);
        chk("t6_async_valid", instr_valid, 0);
        chk("t6_async_busy", busy, 0);
        chk("t6_async_pc", pc, 0);
        sb.delete();
        @(negedge clk);
        rst = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) sb.push_back(20'h50000 | 20'(i));
        sb.push_back(20'h50000 | 20'(4));
        sb.push_back(20'h12345);
        go(5'd5);
        wait_done("t6_rerun_done", 12);
        tick();
        chk("t6_pc", pc, 5);
        chk("t6_sb_empty", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Global watchdog so the bench always ends on its own.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Instruction fetch/sequencer stage directly upstream of the CPU core. It drives the core's 20-bit instruction input, one word per cycle.
- Holds a loadable instruction memory and a program counter. Steps through the loaded program on start and inserts NOP words on stall.
- Stops at a HALT word or at a programmed last address, then signals done.

Parameters:
- INSTR_WIDTH, 20, instruction word width.
- PC_BITS, 5, program-counter width; the memory holds 2^PC_BITS words.
- NOP_INSTR, 20'h00000, word driven whenever no valid instruction is issued.
- HALT_INSTR, 20'hFFFFF, fetched word that terminates the program; it is never issued.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- load_en  in  1  write load_data into memory at load_addr (IDLE/HALT only).
- load_addr  in  PC_BITS  memory write address.
- load_data  in  INSTR_WIDTH  memory write data.
- last_addr  in  PC_BITS  address of the final program word; sampled at start.
- start  in  1  begin execution from address 0.
- stall  in  1  hold the PC and issue NOP this cycle.
- instruction  out  INSTR_WIDTH  registered word to the CPU core.
- instr_valid  out  1  instruction is a real program word.
- pc  out  PC_BITS  address of the next word to fetch.
- busy  out  1  state == RUN.
- done  out  1  state == HALT.

Behaviour:
- States: IDLE, RUN, HALT. All outputs are registered.
- Reset (rst=0, asynchronous):
  - state=IDLE, pc=0, instruction=NOP_INSTR, instr_valid=0, busy=0, done=0.
  - Memory contents are not cleared and survive reset.
- IDLE:
  - load_en=1 writes mem[load_addr] on the edge.
  - start=1 with load_en=0 → RUN, pc=0, last_addr latched internally.
  - start=1 with load_en=1 → write happens, start is ignored, state stays IDLE.
- RUN, each edge with stall=0:
  - Fetched word w=mem[pc].
  - If w==HALT_INSTR: instruction=NOP_INSTR, instr_valid=0, → HALT, pc unchanged.
  - Otherwise: instruction=w, instr_valid=1.
    - If pc==latched last_addr → HALT on the same edge (the last word is still issued, pc unchanged).
    - Else pc=pc+1.
- RUN with stall=1: pc holds, instruction=NOP_INSTR, instr_valid=0. Stall has priority over the halt checks.
- RUN: load_en is ignored and memory is unchanged.
- Latency: the word at address k is presented the cycle after pc==k is fetched without stall. Back-to-back issue is 1 word per cycle.
- No wrap-around: with last_addr=2^PC_BITS-1, the PC stops at the top address and never rolls to 0.
- HALT:
  - instruction=NOP_INSTR, instr_valid=0, done=1.
  - load_en writes are accepted, as in IDLE.
  - start (load_en=0) → RUN from pc=0, done cleared on the same edge.
- Reset asserted mid-RUN: outputs drop to reset values immediately (asynchronously), without waiting for a clock edge.

Test Plan:
- Reset then load: load mem[0..3]={20'h10203,20'h20104,20'h31005,20'h40000}, last_addr=3, start → instruction sequence 10203, 20104, 31005, 40000 on four consecutive cycles with instr_valid=1; then done=1, instruction=00000, instr_valid=0.
- HALT word: mem[2]=20'hFFFFF, last_addr=7 → two valid words issued, then HALT; 20'hFFFFF never appears on instruction; pc=2.
- Stall: raise stall for 2 cycles after the first word → two NOP cycles with instr_valid=0, pc frozen; the program resumes at the next address with no word skipped or repeated.
- Edge cases:
  - last_addr=31 on a full memory with no HALT word → 32 words issued, pc ends at 31 with no wrap.
  - start and load_en together in IDLE → memory written, busy stays 0.
- Reset mid-run: drive rst=0 between clock edges during RUN → instruction=00000, instr_valid=0, busy=0 with no clock edge. After release, start reruns the program from address 0 with memory intact.
